imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage between fetch and execute in the RISC-V core.
- Classifies each instruction's immediate format and builds the sign- or zero-extended immediate at XLEN = WIDTH.
- Flags unsupported opcodes as illegal instead of treating them as I-type.
- Includes a 2-entry skid buffer so back-pressure from execute never drops or reorders instructions.

Parameters:
- WIDTH, 32, datapath/immediate width. Legal values are 32 and 64; any other value is an elaboration error.
- PC_WIDTH, WIDTH, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held and incoming entries (branch redirect).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_inst  in  32  raw instruction.
- in_pc  in  PC_WIDTH  instruction PC.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_inst  out  32  registered instruction.
- out_pc  out  PC_WIDTH  registered PC.
- out_imm  out  WIDTH  generated immediate.
- out_fmt  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6=R (no immediate), 7=NONE (illegal).
- out_illegal  out  1  opcode or encoding not supported.

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, skid empty; out_inst/out_pc/out_imm=0, out_fmt=7, out_illegal=0.
- Transfers:
  - Input transfer occurs on in_valid&in_ready; output transfer on out_valid&out_ready.
  - Latency: an entry accepted in cycle N is on the outputs in cycle N+1.
  - Throughput: 1 entry/cycle while out_ready=1.
- Storage is main register M (drives outputs) plus skid register S.
  - in_ready = !S.valid, which is registered and has no combinational path from out_ready.
  - Accept while M is empty, or M is being consumed this cycle: the entry goes into M.
  - Accept while M is held: the entry goes into S.
  - When M is consumed and S is valid: S moves into M, S is cleared, and in_ready rises the next cycle.
  - Order is strictly FIFO; no entry is ever duplicated or dropped.
- flush: on the next edge both valid bits clear and any input accepted in the same cycle is discarded. in_ready=1 afterwards. Flush takes priority over every other event.
- Immediate decode is combinational on the input side and registered with the entry. Opcode mapping:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111: I, sign-extend inst[31:20].
  - STORE 0100011: S, sign-extend {inst[31:25],inst[11:7]}.
  - BRANCH 1100011: B, sign-extend {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - LUI 0110111, AUIPC 0010111: U, {inst[31:12],12'b0}. Sign-extended from bit 31 when WIDTH=64.
  - JAL 1101111: J, sign-extend {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - SYSTEM 1110011:
    - funct3[2]=1: Z, zero-extended inst[19:15].
    - otherwise: R, imm=0.
  - OP 0110011: R, imm=0.
  - Any other opcode, or inst[1:0]!=2'b11 when the RVC feature is off: fmt=7, illegal=1, imm=0.
- All sign extension targets the full WIDTH. No truncation occurs anywhere.

Optional Feature:
- Macro: IMMGEN_RVC_EN.
- Defined: when inst[1:0]!=2'b11, the 16-bit instruction in inst[15:0] is decoded as follows.
  - I format: C.ADDI4SPN (zero-ext nzuimm), C.LW (zero-ext uimm), C.ADDI/C.LI (sign-ext imm[5:0]), C.LWSP (zero-ext uimm).
  - S format: C.SW, C.SWSP (zero-ext uimm).
  - J format: C.J (sign-ext 12-bit offset).
  - B format: C.BEQZ/C.BNEZ (sign-ext 9-bit offset).
  - Any other quadrant/funct3 combination: illegal.
  - Upper in_inst bits are ignored for compressed encodings.
- Undefined: all compressed encodings are illegal and no RVC logic is synthesised.

Decomposition:
- Shared package/header holds:
  - the opcode constants (existing OPC_* set, plus OPC_OP, OPC_MISC_MEM, OPC_SYSTEM);
  - the 3-bit IMM_FMT_* codes.
- One sub-module: imm_decode, purely combinational (inst → imm, fmt, illegal), instantiated once on the input side.
- The skid buffer and handshake logic live in imm_gen_stage.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1) at WIDTH=32 → next cycle out_imm=0xFFFFFFFF, fmt=0, illegal=0.
- 0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFC, fmt=2.
- WIDTH=64:
  - 0x123452B7 → out_imm=0x0000000012345000, fmt=3.
  - 0x800002B7 → out_imm=0xFFFFFFFF80000000.
- out_ready=0 for 3 cycles while streaming A, B, C:
  - A held in M, B in S.
  - in_ready=0 with C pending.
  - Release out_ready → A, B, C emerge in order on consecutive cycles, with no duplicates.
- Two entries buffered, flush=1 for one cycle with in_valid=1 → out_valid=0 next cycle, the flushed input never appears, in_ready=1.
- 0x0000007F → illegal=1, fmt=7, imm=0.
- With IMMGEN_RVC_EN, 0x50FD (c.li x1,-1) → imm=all ones, fmt=0. Without the macro → illegal=1.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants and immediate format codes for imm_gen_stage.
// Imported by imm_decode and imm_gen_stage.
package imm_gen_stage_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] IMM_FMT_I    = 3'd0;
    localparam logic [2:0] IMM_FMT_S    = 3'd1;
    localparam logic [2:0] IMM_FMT_B    = 3'd2;
    localparam logic [2:0] IMM_FMT_U    = 3'd3;
    localparam logic [2:0] IMM_FMT_J    = 3'd4;
    localparam logic [2:0] IMM_FMT_Z    = 3'd5;
    localparam logic [2:0] IMM_FMT_R    = 3'd6;
    localparam logic [2:0] IMM_FMT_NONE = 3'd7;

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// imm_decode: combinational immediate classifier/builder (inst -> imm, fmt, illegal).
// Ports: i_inst[31:0]; o_imm[WIDTH-1:0], o_fmt[2:0], o_illegal. Macro IMMGEN_RVC_EN adds RVC.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      i_inst,
    output logic [WIDTH-1:0] o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal
);

    logic [6:0] w_opc;
    assign w_opc = i_inst[6:0];

    always_comb begin
        o_imm     = '0;
        o_fmt     = IMM_FMT_NONE;
        o_illegal = 1'b1;
        if (i_inst[1:0] == 2'b11) begin
            o_illegal = 1'b0;
            unique case (w_opc)
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
                    o_fmt = IMM_FMT_I;
                    o_imm = {{(WIDTH-12){i_inst[31]}}, i_inst[31:20]};
                end
                OPC_STORE: begin
                    o_fmt = IMM_FMT_S;
                    o_imm = {{(WIDTH-12){i_inst[31]}},
                             i_inst[31:25], i_inst[11:7]};
                end
                OPC_BRANCH: begin
                    o_fmt = IMM_FMT_B;
                    o_imm = {{(WIDTH-12){i_inst[31]}}, i_inst[7],
                             i_inst[30:25], i_inst[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    // bit 31 replicated so RV64 gets the sign-extended upper imm
                    o_fmt = IMM_FMT_U;
                    o_imm = {{(WIDTH-31){i_inst[31]}},
                             i_inst[30:12], 12'b0};
                end
                OPC_JAL: begin
                    o_fmt = IMM_FMT_J;
                    o_imm = {{(WIDTH-20){i_inst[31]}}, i_inst[19:12],
                             i_inst[20], i_inst[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    if (i_inst[14]) begin
                        o_fmt = IMM_FMT_Z;
                        o_imm = {{(WIDTH-5){1'b0}}, i_inst[19:15]};
                    end else begin
                        o_fmt = IMM_FMT_R;
                    end
                end
                OPC_OP: begin
                    o_fmt = IMM_FMT_R;
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end
`ifdef IMMGEN_RVC_EN
        else begin
            o_illegal = 1'b0;
            // key = {quadrant, funct3}
            unique case ({i_inst[1:0], i_inst[15:13]})
                5'b00_000: begin
                    o_fmt = IMM_FMT_I;
                    o_imm = {{(WIDTH-10){1'b0}}, i_inst[10:7],
                             i_inst[12:11], i_inst[5], i_inst[6], 2'b00};
                end
                5'b00_010, 5'b00_110: begin
                    o_fmt = i_inst[15] ? IMM_FMT_S : IMM_FMT_I;
                    o_imm = {{(WIDTH-7){1'b0}}, i_inst[5],
                             i_inst[12:10], i_inst[6], 2'b00};
                end
                5'b01_000, 5'b01_010: begin
                    o_fmt = IMM_FMT_I;
                    o_imm = {{(WIDTH-5){i_inst[12]}}, i_inst[6:2]};
                end
                5'b01_101: begin
                    o_fmt = IMM_FMT_J;
                    o_imm = {{(WIDTH-11){i_inst[12]}}, i_inst[8],
                             i_inst[10:9], i_inst[6], i_inst[7],
                             i_inst[2], i_inst[11], i_inst[5:3], 1'b0};
                end
                5'b01_110, 5'b01_111: begin
                    o_fmt = IMM_FMT_B;
                    o_imm = {{(WIDTH-8){i_inst[12]}}, i_inst[6:5],
                             i_inst[2], i_inst[11:10], i_inst[4:3], 1'b0};
                end
                5'b10_010: begin
                    o_fmt = IMM_FMT_I;
                    o_imm = {{(WIDTH-8){1'b0}}, i_inst[3:2],
                             i_inst[12], i_inst[6:4], 2'b00};
                end
                5'b10_110: begin
                    o_fmt = IMM_FMT_S;
                    o_imm = {{(WIDTH-8){1'b0}}, i_inst[8:7],
                             i_inst[12:9], 2'b00};
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end
`endif
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with a 2-entry skid buffer.
// Ports: clk, rst, flush, in_valid/in_ready/in_inst/in_pc, out_valid/out_ready/out_inst/out_pc/out_imm/out_fmt/out_illegal. Macro IMMGEN_RVC_EN.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0]    out_imm,
    output logic [2:0]          out_fmt,
    output logic                out_illegal
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("imm_gen_stage: WIDTH must be 32 or 64");
    end

    logic [WIDTH-1:0] w_imm;
    logic [2:0]       w_fmt;
    logic             w_illegal;

    imm_decode #(.WIDTH(WIDTH)) u_dec (
        .i_inst    (in_inst),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    logic                r_m_valid, r_s_valid;
    logic [31:0]         r_m_inst, r_s_inst;
    logic [PC_WIDTH-1:0] r_m_pc, r_s_pc;
    logic [WIDTH-1:0]    r_m_imm, r_s_imm;
    logic [2:0]          r_m_fmt, r_s_fmt;
    logic                r_m_ill, r_s_ill;

    logic w_m_free;
    logic w_in_fire;

    // M can take a new entry if empty or drained this cycle
    assign w_m_free  = !r_m_valid || out_ready;
    assign w_in_fire = in_valid && !r_s_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_inst  <= '0;
            r_m_pc    <= '0;
            r_m_imm   <= '0;
            r_m_fmt   <= IMM_FMT_NONE;
            r_m_ill   <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_inst  <= '0;
            r_s_pc    <= '0;
            r_s_imm   <= '0;
            r_s_fmt   <= IMM_FMT_NONE;
            r_s_ill   <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_m_free) begin
            if (r_s_valid) begin
                // in_ready is low here, so no input competes with S
                r_m_valid <= 1'b1;
                r_m_inst  <= r_s_inst;
                r_m_pc    <= r_s_pc;
                r_m_imm   <= r_s_imm;
                r_m_fmt   <= r_s_fmt;
                r_m_ill   <= r_s_ill;
                r_s_valid <= 1'b0;
            end else begin
                r_m_valid <= in_valid;
                if (in_valid) begin
                    r_m_inst <= in_inst;
                    r_m_pc   <= in_pc;
                    r_m_imm  <= w_imm;
                    r_m_fmt  <= w_fmt;
                    r_m_ill  <= w_illegal;
                end
            end
        end else if (w_in_fire) begin
            r_s_valid <= 1'b1;
            r_s_inst  <= in_inst;
            r_s_pc    <= in_pc;
            r_s_imm   <= w_imm;
            r_s_fmt   <= w_fmt;
            r_s_ill   <= w_illegal;
        end
    end

    assign in_ready    = !r_s_valid;
    assign out_valid   = r_m_valid;
    assign out_inst    = r_m_inst;
    assign out_pc      = r_m_pc;
    assign out_imm     = r_m_imm;
    assign out_fmt     = r_m_fmt;
    assign out_illegal = r_m_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: WIDTH=32 and WIDTH=64 instances share stimulus.
// Reference is a FIFO queue plus an arithmetic immediate model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        rdy32, vld32, ill32;
    logic [31:0] inst32, pc32, imm32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [31:0] inst64;
    logic [63:0] pc64, imm64;
    logic [2:0]  fmt64;

    always #5 clk = ~clk;

    imm_gen_stage #(.WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(vld32), .out_ready(out_ready),
        .out_inst(inst32), .out_pc(pc32), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_stage #(.WIDTH(64)) u_d64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(vld64), .out_ready(out_ready),
        .out_inst(inst64), .out_pc(pc64), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint fld(input logic [31:0] inst,
                                   input int hi, input int lo);
        longint x;
        x = longint'({32'd0, inst});
        return (x >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1)))
            return v - (longint'(1) << bits);
        return v;
    endfunction

    task automatic ref_dec(input logic [31:0] inst, output longint imm,
                           output int fmt, output bit ill);
        imm = 0;
        fmt = 7;
        if (inst[1:0] == 2'b11) begin
            case (fld(inst, 6, 0))
                'h03, 'h13, 'h67, 'h0F: begin
                    fmt = 0;
                    imm = sx(fld(inst, 31, 20), 12);
                end
                'h23: begin
                    fmt = 1;
                    imm = sx(fld(inst, 31, 25) * 32 + fld(inst, 11, 7), 12);
                end
                'h63: begin
                    fmt = 2;
                    imm = sx(fld(inst, 31, 31) * 4096 + fld(inst, 7, 7) * 2048
                             + fld(inst, 30, 25) * 32 + fld(inst, 11, 8) * 2, 13);
                end
                'h37, 'h17: begin
                    fmt = 3;
                    imm = sx(fld(inst, 31, 12) * 4096, 32);
                end
                'h6F: begin
                    fmt = 4;
                    imm = sx(fld(inst, 31, 31) * (1 << 20)
                             + fld(inst, 19, 12) * 4096
                             + fld(inst, 20, 20) * 2048
                             + fld(inst, 30, 21) * 2, 21);
                end
                'h73: begin
                    if (inst[14]) begin
                        fmt = 5;
                        imm = fld(inst, 19, 15);
                    end else begin
                        fmt = 6;
                    end
                end
                'h33: fmt = 6;
                default: fmt = 7;
            endcase
        end
`ifdef IMMGEN_RVC_EN
        else begin
            case (fld(inst, 1, 0) * 8 + fld(inst, 15, 13))
                0: begin
                    fmt = 0;
                    imm = fld(inst, 10, 7) * 64 + fld(inst, 12, 11) * 16
                          + fld(inst, 5, 5) * 8 + fld(inst, 6, 6) * 4;
                end
                2, 6: begin
                    fmt = (inst[15]) ? 1 : 0;
                    imm = fld(inst, 5, 5) * 64 + fld(inst, 12, 10) * 8
                          + fld(inst, 6, 6) * 4;
                end
                8, 10: begin
                    fmt = 0;
                    imm = sx(fld(inst, 12, 12) * 32 + fld(inst, 6, 2), 6);
                end
                13: begin
                    fmt = 4;
                    imm = sx(fld(inst, 12, 12) * 2048 + fld(inst, 11, 11) * 16
                             + fld(inst, 10, 9) * 256 + fld(inst, 8, 8) * 1024
                             + fld(inst, 7, 7) * 64 + fld(inst, 6, 6) * 128
                             + fld(inst, 5, 3) * 2 + fld(inst, 2, 2) * 32, 12);
                end
                14, 15: begin
                    fmt = 2;
                    imm = sx(fld(inst, 12, 12) * 256 + fld(inst, 11, 10) * 8
                             + fld(inst, 6, 5) * 64 + fld(inst, 4, 3) * 2
                             + fld(inst, 2, 2) * 32, 9);
                end
                18: begin
                    fmt = 0;
                    imm = fld(inst, 3, 2) * 64 + fld(inst, 12, 12) * 32
                          + fld(inst, 6, 4) * 4;
                end
                22: begin
                    fmt = 1;
                    imm = fld(inst, 8, 7) * 64 + fld(inst, 12, 9) * 4;
                end
                default: fmt = 7;
            endcase
        end
`endif
        ill = (fmt == 7);
    endtask

    task automatic step(input logic v, input logic [31:0] inst,
                        input logic [63:0] pc, input logic rdy,
                        input logic fl);
        bit     acc;
        ent_t   e;
        longint imm;
        int     fmt;
        bit     ill;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        acc = (q.size() < 2);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (v && acc) begin
                e.inst = inst;
                e.pc   = pc;
                q.push_back(e);
            end
        end
        #1;
        chk("in_ready32", rdy32, q.size() < 2);
        chk("in_ready64", rdy64, q.size() < 2);
        chk("out_valid32", vld32, q.size() > 0);
        chk("out_valid64", vld64, q.size() > 0);
        if (q.size() > 0) begin
            ref_dec(q[0].inst, imm, fmt, ill);
            chk("inst32", inst32, q[0].inst);
            chk("inst64", inst64, q[0].inst);
            chk("pc32", pc32, q[0].pc & 64'hFFFF_FFFF);
            chk("pc64", pc64, q[0].pc);
            chk("imm32", imm32, imm & 64'hFFFF_FFFF);
            chk("imm64", imm64, imm);
            chk("fmt32", fmt32, fmt);
            chk("fmt64", fmt64, fmt);
            chk("ill32", ill32, ill);
            chk("ill64", ill64, ill);
        end
    endtask

    logic [6:0] opcs [13] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h73,
                              7'h33, 7'h7F, 7'h0B};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 13);
        if (k < 13) r[6:0] = opcs[k];
        return r;
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        #12;
        chk("rst_out_valid", vld32, 1'b0);
        chk("rst_in_ready", rdy32, 1'b1);
        chk("rst_inst", inst32, 0);
        chk("rst_pc", pc64, 0);
        chk("rst_imm", imm64, 0);
        chk("rst_fmt", fmt32, 7);
        chk("rst_ill", ill32, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(1, 32'hFFF00093, 64'h100, 1, 0);
        chk("addi_imm", imm32, 32'hFFFF_FFFF);
        chk("addi_fmt", fmt32, 0);
        chk("addi_ill", ill32, 0);
        step(1, 32'hFE000EE3, 64'h104, 1, 0);
        chk("beq_imm", imm32, 32'hFFFF_FFFC);
        chk("beq_fmt", fmt32, 2);
        step(1, 32'h123452B7, 64'h108, 1, 0);
        chk("lui_imm64", imm64, 64'h0000_0000_1234_5000);
        chk("lui_fmt", fmt64, 3);
        step(1, 32'h800002B7, 64'h10C, 1, 0);
        chk("lui_neg64", imm64, 64'hFFFF_FFFF_8000_0000);
        step(1, 32'h0000007F, 64'h110, 1, 0);
        chk("bad_ill", ill32, 1);
        chk("bad_fmt", fmt32, 7);
        chk("bad_imm", imm64, 0);
        step(1, 32'h000050FD, 64'h114, 1, 0);
`ifdef IMMGEN_RVC_EN
        chk("cli_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("cli_fmt", fmt32, 0);
`else
        chk("cli_ill", ill32, 1);
        chk("cli_fmt", fmt32, 7);
`endif
        step(0, 0, 0, 1, 0);

        // stall with A, B, C
        step(1, 32'h00A00093, 64'hA0, 0, 0);
        chk("stall_A_in_M", inst32, 32'h00A00093);
        step(1, 32'h00B00093, 64'hB0, 0, 0);
        chk("stall_full", rdy32, 0);
        step(1, 32'h00C00093, 64'hC0, 0, 0);
        chk("stall_C_pend", rdy32, 0);
        chk("stall_A_hold", inst32, 32'h00A00093);
        step(1, 32'h00C00093, 64'hC0, 1, 0);
        chk("rel_B", inst32, 32'h00B00093);
        step(1, 32'h00C00093, 64'hC0, 1, 0);
        chk("rel_C", inst32, 32'h00C00093);
        step(0, 0, 0, 1, 0);
        chk("rel_empty", vld32, 0);

        // flush with two buffered and an input pending
        step(1, 32'h00100093, 64'h200, 0, 0);
        step(1, 32'h00200093, 64'h204, 0, 0);
        step(1, 32'h00300093, 64'h208, 0, 1);
        chk("flush_valid", vld32, 0);
        chk("flush_ready", rdy32, 1);
        step(1, 32'h00400093, 64'h20C, 1, 0);
        chk("post_flush", inst32, 32'h00400093);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(),
                 {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
